axis_frame_scheduler: RTL and testbench

Real-time frame pacer between the DMA MM2S stream and the stream generator / FFT input. Releases exactly one frame of FRAME_LEN samples per PERIOD-cycle sampling interval, generates TLAST on the last beat, and holds the stream closed between frames. Monitors the processing deadline: a frame still in flight when the next period tick fires is a deadline miss. Frame and miss counters are exposed to the PS-side status registers.

---
 rtl/axis_frame_scheduler.sv | 175 +++++++++++++++++
 tb/tb_axis_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_scheduler.sv
// axis_frame_scheduler
// Paces an AXI-Stream source into fixed-length frames, one frame per
// sampling period. TLAST is generated from a beat counter, the stream is
// closed between frames, and a frame still running when the next period
// tick fires is counted as a deadline miss.
module axis_frame_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int PERIOD     = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  BUSY,
  output logic                  MISS_PULSE,
  output logic [CNT_WIDTH-1:0]  FRAME_COUNT,
  output logic [CNT_WIDTH-1:0]  MISS_COUNT
);

  localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [PCNT_W-1:0]    PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                 miss_pulse_q, miss_pulse_d;
  logic                 busy_q, busy_d;

  logic in_pass;
  logic tick;
  logic xfer;
  logic last_beat;
  logic last_xfer;

  // Frame boundaries come only from the beat counter; upstream TLAST is
  // deliberately not used.
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;

  assign in_pass   = (state_q == ST_PASS);
  assign tick      = EN && (pcnt_q == PCNT_LAST);
  assign last_beat = (beat_q == BEAT_LAST);
  assign xfer      = in_pass && S_AXIS_TVALID && M_AXIS_TREADY;
  assign last_xfer = xfer && last_beat;

  // Stream is a zero-latency pass-through that is gated shut outside PASS.
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TVALID = in_pass && S_AXIS_TVALID;
  assign S_AXIS_TREADY = in_pass && M_AXIS_TREADY;
  assign M_AXIS_TLAST  = in_pass && last_beat;

  assign BUSY        = busy_q;
  assign MISS_PULSE  = miss_pulse_q;
  assign FRAME_COUNT = frame_cnt_q;
  assign MISS_COUNT  = miss_cnt_q;

  // Free-running period counter, held at zero while the scheduler is disabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing assignment would infer a latch.
    pcnt_d = '0;
    if (EN) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
    end
  end

  // Next-state logic for the frame FSM, beat counter and status counters.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    frame_cnt_d  = frame_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    miss_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (EN) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (tick) begin
          state_d = ST_PASS;
          beat_d  = '0;
        end else if (!EN) begin
          state_d = ST_IDLE;
        end
      end

      ST_PASS: begin
        if (last_xfer) begin
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          beat_d      = '0;
          // A tick coinciding with the final beat opens the next frame
          // directly and is not a miss.
          if (tick) begin
            state_d = ST_PASS;
          end else if (EN) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            beat_d = beat_q + BEAT_W'(1);
          end
          // Deadline missed: flag it and let the frame finish; the tick
          // itself is dropped rather than queued.
          if (tick) begin
            miss_pulse_d = 1'b1;
            if (miss_cnt_q != CNT_MAX) begin
              miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // BUSY is registered and tracks the state being entered.
  always_comb begin
    busy_d = (state_d == ST_PASS);
  end

  // State and status registers with synchronous reset; reset mid-frame
  // aborts the frame without touching the counters beyond clearing them.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (ARESET) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      beat_q       <= '0;
      frame_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      miss_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      beat_q       <= beat_d;
      frame_cnt_q  <= frame_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      miss_pulse_q <= miss_pulse_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Testbench for axis_frame_scheduler with FRAME_LEN=4, PERIOD=8.
// A second instance with 2-bit counters shares the stimulus to exercise
// frame-count wrap and miss-count saturation.
module tb_axis_frame_scheduler;

  localparam int FL = 4;
  localparam int P  = 8;

  logic        aclk     = 1'b0;
  logic        areset   = 1'b1;
  logic        en       = 1'b0;
  logic [31:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        m_tready = 1'b0;

  logic        s_tready, m_tvalid, m_tlast, busy, miss_pulse;
  logic [31:0] m_tdata;
  logic [15:0] frame_count, miss_count;

  logic        sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_busy, sat_miss_pulse;
  logic [31:0] sat_m_tdata;
  logic [1:0]  sat_frame_count, sat_miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = -1;
  logic        hold = 1'b0;
  logic [31:0] d_saved;

  // Reference model state: period phase, whether a frame is open, beats
  // already delivered in it, and unbounded event totals.
  int m_phase     = 0;
  bit m_in_frame  = 1'b0;
  int m_beats     = 0;
  int m_frames    = 0;
  int m_misses    = 0;
  bit m_pulse     = 1'b0;

  always #5 aclk = ~aclk;

  axis_frame_scheduler #(
    .DATA_WIDTH(32), .FRAME_LEN(FL), .PERIOD(P), .CNT_WIDTH(16)
  ) dut (
    .ACLK(aclk), .ARESET(areset), .EN(en),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .BUSY(busy), .MISS_PULSE(miss_pulse),
    .FRAME_COUNT(frame_count), .MISS_COUNT(miss_count)
  );

  axis_frame_scheduler #(
    .DATA_WIDTH(32), .FRAME_LEN(FL), .PERIOD(P), .CNT_WIDTH(2)
  ) dut_sat (
    .ACLK(aclk), .ARESET(areset), .EN(en),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(sat_s_tready),
    .M_AXIS_TDATA(sat_m_tdata), .M_AXIS_TVALID(sat_m_tvalid), .M_AXIS_TLAST(sat_m_tlast),
    .M_AXIS_TREADY(m_tready),
    .BUSY(sat_busy), .MISS_PULSE(sat_miss_pulse),
    .FRAME_COUNT(sat_frame_count), .MISS_COUNT(sat_miss_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns at the falling edge of that cycle.
  // Data is held while the previous beat was offered but stalled.
  task automatic drive(input logic rst, input logic e, input logic sv, input logic mr);
    @(posedge aclk);
    #1;
    areset   = rst;
    en       = e;
    s_tvalid = sv;
    m_tready = mr;
    s_tlast  = 1'($urandom_range(0, 1));
    if (!hold) s_tdata = $urandom;
    t++;
    @(negedge aclk);
    hold = s_tvalid && !s_tready;
  endtask

  task automatic start();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    t = -1;
  endtask

  // Compare process: every falling edge, check both DUTs against the model,
  // then advance the model with the inputs that the next rising edge samples.
  initial begin
    bit tick, xfer, last;
    forever begin
      @(negedge aclk);
      check("busy",        busy,        m_in_frame);
      check("m_tvalid",    m_tvalid,    m_in_frame && s_tvalid);
      check("s_tready",    s_tready,    m_in_frame && m_tready);
      check("m_tlast",     m_tlast,     m_in_frame && (m_beats == FL - 1));
      check("m_tdata",     m_tdata,     s_tdata);
      check("miss_pulse",  miss_pulse,  m_pulse);
      check("frame_count", frame_count, m_frames % 65536);
      check("miss_count",  miss_count,  (m_misses > 65535) ? 65535 : m_misses);
      check("sat_busy",    sat_busy,    m_in_frame);
      check("sat_stream",  {sat_m_tvalid, sat_s_tready, sat_m_tlast},
            {m_in_frame && s_tvalid, m_in_frame && m_tready, m_in_frame && (m_beats == FL - 1)});
      check("sat_m_tdata", sat_m_tdata, s_tdata);
      check("sat_miss_pulse",  sat_miss_pulse,  m_pulse);
      check("sat_frame_count", sat_frame_count, m_frames % 4);
      check("sat_miss_count",  sat_miss_count,  (m_misses > 3) ? 3 : m_misses);

      if (areset) begin
        m_phase = 0; m_in_frame = 0; m_beats = 0;
        m_frames = 0; m_misses = 0; m_pulse = 0;
      end else begin
        tick    = en && (m_phase == P - 1);
        xfer    = m_in_frame && s_tvalid && m_tready;
        last    = xfer && (m_beats == FL - 1);
        m_pulse = m_in_frame && tick && !last;
        if (m_pulse) m_misses++;
        if (last) m_frames++;
        m_phase = en ? (m_phase + 1) % P : 0;
        if (m_in_frame && !last) begin
          m_beats = m_beats + (xfer ? 1 : 0);
        end else begin
          m_beats    = 0;
          m_in_frame = m_in_frame ? tick : tick;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Nominal: frames in 8-11, 16-19, ...; five frames by cycle 44.
    start();
    for (int c = 0; c <= 44; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      case (c)
        7:  check("A_busy7", busy, 0);
        8:  begin check("A_busy8", busy, 1); check("A_tvalid8", m_tvalid, 1); end
        10: check("A_tlast10", m_tlast, 0);
        11: begin check("A_tlast11", m_tlast, 1); check("A_fc11", frame_count, 0); end
        12: begin check("A_fc12", frame_count, 1); check("A_busy12", busy, 0); check("A_tready12", s_tready, 0); end
        16: check("A_busy16", busy, 1);
        19: check("A_tlast19", m_tlast, 1);
        20: begin check("A_fc20", frame_count, 2); check("A_mc20", miss_count, 0); end
        44: begin check("A_fc44", frame_count, 5); check("A_satfc44", sat_frame_count, 1); end
        default: ;
      endcase
    end

    // Backpressure: downstream ready alternates from cycle 8.
    start();
    for (int c = 0; c <= 17; c++) begin
      drive(1'b0, 1'b1, 1'b1, (c < 8) ? 1'b1 : 1'((c % 2) == 0));
      case (c)
        9:  begin check("B_tready9", s_tready, 0); check("B_tvalid9", m_tvalid, 1); d_saved = s_tdata; end
        10: begin check("B_tready10", s_tready, 1); check("B_hold10", m_tdata, d_saved); end
        13: begin check("B_tlast13", m_tlast, 1); check("B_tready13", s_tready, 0); end
        14: check("B_tlast14", m_tlast, 1);
        15: begin check("B_fc15", frame_count, 1); check("B_busy15", busy, 0); end
        16: begin check("B_busy16", busy, 1); check("B_mc16", miss_count, 0); check("B_mp16", miss_pulse, 0); end
        default: ;
      endcase
    end

    // Late frame: source idle in 9-16, tick at 15 is a miss.
    start();
    for (int c = 0; c <= 26; c++) begin
      drive(1'b0, 1'b1, 1'(!(c >= 9 && c <= 16)), 1'b1);
      case (c)
        15: begin check("C_mp15", miss_pulse, 0); check("C_busy15", busy, 1); end
        16: begin check("C_mp16", miss_pulse, 1); check("C_mc16", miss_count, 1); end
        17: begin check("C_mp17", miss_pulse, 0); check("C_busy17", busy, 1); end
        19: check("C_tlast19", m_tlast, 1);
        20: begin check("C_fc20", frame_count, 1); check("C_busy20", busy, 0); end
        23: check("C_busy23", busy, 0);
        24: begin check("C_busy24", busy, 1); check("C_mc24", miss_count, 1); end
        default: ;
      endcase
    end

    // Coincident: last beat lands exactly on the tick at cycle 15.
    start();
    for (int c = 0; c <= 20; c++) begin
      drive(1'b0, 1'b1, 1'(!(c >= 9 && c <= 12)), 1'b1);
      case (c)
        15: begin check("D_tlast15", m_tlast, 1); check("D_busy15", busy, 1); end
        16: begin
          check("D_busy16", busy, 1); check("D_tlast16", m_tlast, 0);
          check("D_fc16", frame_count, 1); check("D_mp16", miss_pulse, 0);
          check("D_tvalid16", m_tvalid, 1);
        end
        20: begin check("D_fc20", frame_count, 2); check("D_busy20", busy, 0); check("D_mc20", miss_count, 0); end
        default: ;
      endcase
    end

    // Enable drop after two beats, then re-enable at cycle 17.
    start();
    for (int c = 0; c <= 30; c++) begin
      drive(1'b0, 1'(!(c >= 10 && c <= 16)), 1'b1, 1'b1);
      case (c)
        10: begin check("E_busy10", busy, 1); check("E_tvalid10", m_tvalid, 1); end
        11: check("E_tlast11", m_tlast, 1);
        12: begin check("E_busy12", busy, 0); check("E_tready12", s_tready, 0); check("E_fc12", frame_count, 1); end
        24: check("E_busy24", busy, 0);
        25: check("E_busy25", busy, 1);
        default: ;
      endcase
    end

    // Reset in cycle 10 mid-frame.
    start();
    for (int c = 0; c <= 12; c++) begin
      drive(1'(c == 10), 1'b1, 1'b1, 1'b1);
      if (c == 11) begin
        check("F_busy11", busy, 0);     check("F_tvalid11", m_tvalid, 0);
        check("F_tready11", s_tready, 0); check("F_tlast11", m_tlast, 0);
        check("F_mp11", miss_pulse, 0); check("F_fc11", frame_count, 0);
        check("F_mc11", miss_count, 0);
      end
    end

    // Five misses on one stalled frame, then reset clears the counters.
    start();
    for (int c = 0; c <= 53; c++) begin
      drive(1'(c == 52), 1'b1, 1'(c == 8 || c >= 48), 1'b1);
      case (c)
        24: check("G_satmc24", sat_miss_count, 2);
        40: begin check("G_mc40", miss_count, 4); check("G_satmc40", sat_miss_count, 3); end
        48: begin
          check("G_mc48", miss_count, 5); check("G_satmc48", sat_miss_count, 3);
          check("G_mp48", miss_pulse, 1); check("G_satmp48", sat_miss_pulse, 1);
        end
        50: check("G_tlast50", m_tlast, 1);
        51: begin check("G_fc51", frame_count, 1); check("G_satfc51", sat_frame_count, 1); end
        53: begin
          check("G_mc53", miss_count, 0); check("G_satmc53", sat_miss_count, 0);
          check("G_fc53", frame_count, 0); check("G_busy53", busy, 0);
        end
        default: ;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
